// File: rtl/ipsm_pkg.sv
// Shared image-path constants and state encoding for the DMEM image capture and streamer blocks.
package ipsm_pkg;

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

    localparam int IMG_DIM     = 28;
    localparam int IMG_PIX     = IMG_DIM * IMG_DIM;
    localparam int PIX_BITS    = 8;
    localparam int DMEM_WORD_W = 256;
    localparam int DMEM_ADDR_W = 7;
    localparam int PPW         = DMEM_WORD_W / PIX_BITS;

    // Number of DMEM words needed to hold num_pix pixels, last word possibly partial.
    function automatic int words_for(input int num_pix, input int ppw = PPW);
        return (num_pix + ppw - 1) / ppw;
    endfunction

endpackage

// File: rtl/img_word_shifter.sv
// Word-wide load/shift register: presents pixel 0 of the loaded word and shifts one pixel per request,
// tracking how many valid pixels of the word remain.
module img_word_shifter
    import ipsm_pkg::*;
#(
    parameter int PIX_W  = PIX_BITS,
    parameter int WORD_W = DMEM_WORD_W,
    parameter int CNT_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_loadData,
    input  logic [CNT_W-1:0]  i_loadCount,
    input  logic              i_shift,
    output logic [PIX_W-1:0]  o_pixel,
    output logic              o_last
);

    logic [WORD_W-1:0] r_data;
    logic [CNT_W-1:0]  r_remain;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data   <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_data   <= i_loadData;
            r_remain <= i_loadCount;
        end else if (i_shift) begin
            r_data   <= {{PIX_W{1'b0}}, r_data[WORD_W-1:PIX_W]};
            r_remain <= r_remain - CNT_W'(1);
        end
    end

    assign o_pixel = r_data[PIX_W-1:0];
    assign o_last  = (r_remain == CNT_W'(1));

endmodule

// File: rtl/dmem_img_streamer.sv
// Streams a stored image out of DMEM, one word read at a time, as a byte stream to the SPART transmitter.
module dmem_img_streamer
    import ipsm_pkg::*;
#(
    parameter int PIX_W   = PIX_BITS,
    parameter int WORD_W  = DMEM_WORD_W,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int NUM_PIX = IMG_PIX,
    parameter int RD_LAT  = 1
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic [ADDR_W-1:0] iBASE_ADDR,
    output logic              oDmem_rden,
    output logic [ADDR_W-1:0] oDmem_rdaddr,
    input  logic [WORD_W-1:0] iDmem_rddata,
    output logic [PIX_W-1:0]  oTX_data,
    output logic              oTX_valid,
    input  logic              iTX_ready,
    output logic              oBusy,
    output logic              oDone
);

    localparam int PPW_L    = WORD_W / PIX_W;
    localparam int WORDS    = words_for(NUM_PIX, PPW_L);
    localparam int LAST_CNT = NUM_PIX - (WORDS - 1) * PPW_L;
    localparam int PIXC_W   = $clog2(NUM_PIX + 1);
    localparam int WRDC_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int REMC_W   = $clog2(PPW_L + 1);
    localparam int LATC_W   = $clog2(RD_LAT + 1);

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_base;
    logic [WRDC_W-1:0] r_word;
    logic [PIXC_W-1:0] r_pix;
    logic [LATC_W-1:0] r_lat;

    logic              w_hs;
    logic              w_latDone;
    logic              w_lastInWord;
    logic              w_finalPix;
    logic [PIX_W-1:0]  w_pixel;
    logic [REMC_W-1:0] w_loadCount;

    assign w_hs        = (r_state == SEND) && iTX_ready;
    assign w_latDone   = (r_lat == LATC_W'(RD_LAT - 1));
    assign w_finalPix  = (r_pix == PIXC_W'(NUM_PIX - 1));
    assign w_loadCount = (r_word == WRDC_W'(WORDS - 1)) ? REMC_W'(LAST_CNT) : REMC_W'(PPW_L);

    assign oDmem_rdaddr = r_base + ADDR_W'(r_word);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The data word is only captured on the final latency cycle, so nothing is prefetched.
    always_comb begin
        w_next     = r_state;
        oDmem_rden = 1'b0;
        oTX_valid  = 1'b0;
        oTX_data   = '0;
        oBusy      = 1'b0;
        oDone      = 1'b0;
        case (r_state)
            IDLE: begin
                if (iSTART) begin
                    w_next = READ;
                end
            end
            READ: begin
                oDmem_rden = 1'b1;
                oBusy      = 1'b1;
                w_next     = WAIT;
            end
            WAIT: begin
                oBusy = 1'b1;
                if (w_latDone) begin
                    w_next = SEND;
                end
            end
            SEND: begin
                oBusy     = 1'b1;
                oTX_valid = 1'b1;
                oTX_data  = w_pixel;
                if (iTX_ready) begin
                    if (w_finalPix) begin
                        w_next = DONE;
                    end else if (w_lastInWord) begin
                        w_next = READ;
                    end
                end
            end
            DONE: begin
                oDone  = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_base <= '0;
            r_word <= '0;
            r_pix  <= '0;
            r_lat  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (iSTART) begin
                        r_base <= iBASE_ADDR;
                        r_word <= '0;
                        r_pix  <= '0;
                    end
                end
                READ: begin
                    r_lat <= '0;
                end
                WAIT: begin
                    r_lat <= r_lat + LATC_W'(1);
                end
                SEND: begin
                    if (w_hs) begin
                        r_pix <= r_pix + PIXC_W'(1);
                        if (w_lastInWord && !w_finalPix) begin
                            r_word <= r_word + WRDC_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    img_word_shifter #(
        .PIX_W  (PIX_W),
        .WORD_W (WORD_W),
        .CNT_W  (REMC_W)
    ) u_shifter (
        .i_clk       (iCLK),
        .i_rst       (iRST),
        .i_load      ((r_state == WAIT) && w_latDone),
        .i_loadData  (iDmem_rddata),
        .i_loadCount (w_loadCount),
        .i_shift     (w_hs),
        .o_pixel     (w_pixel),
        .o_last      (w_lastInWord)
    );

endmodule
